tap_data_path: RTL and testbench
================================

TAP_DATA_PATH -- requirements
Module: tap_data_path

Interface
REQ-001 Parameter: IR_WIDTH, 4, instruction register width in bits (minimum 2).
REQ-002 Parameter: IDCODE_VAL, 32'h1000_0001, device identification value (bit 0 SHALL be 1).
REQ-003 Parameter: USER_WIDTH, 8, user data register width in bits.
REQ-004 Port: tclk  input  1  test clock; all state changes on its rising edge.
REQ-005 Port: trst  input  1  reset, synchronous, active-high.
REQ-006 Port: tap_state  input  5  registered TAP controller state, encoded as 0 RESET, 1 IDLE, 2 SELECT_DR_SCAN, 3 CAPTURE_DR, 4 SHIFT_DR, 5 EXIT1_DR, 6 PAUSE_DR, 7 EXIT2_DR, 8 UPDATE_DR, 9 SELECT_IR_SCAN, 10 CAPTURE_IR, 11 SHIFT_IR, 12 EXIT1_IR, 13 PAUSE_IR, 14 EXIT2_IR, 15 UPDATE_IR; codes 16-31 are treated as IDLE.
REQ-007 Port: tdi  input  1  serial test data in.
REQ-008 Port: user_in  input  USER_WIDTH  parallel value captured into the user DR.
REQ-009 Port: tdo  output  1  serial test data out.
REQ-010 Port: tdo_en  output  1  high while tap_state is SHIFT_IR or SHIFT_DR.
REQ-011 Port: ir  output  IR_WIDTH  current (updated) instruction.
REQ-012 Port: user_out  output  USER_WIDTH  updated user DR value.

Function
REQ-013 Instructions SHALL be: IDCODE = 1, USER = 2, BYPASS = all ones; any other value SHALL select BYPASS.
REQ-014 CAPTURE_IR SHALL load ir_shift with binary ...0001 (bit 0 = 1, bit 1 = 0, upper bits 0).
REQ-015 SHIFT_IR SHALL shift ir_shift right one bit per cycle, tdi into MSB; tdo = ir_shift[0] combinationally.
REQ-016 UPDATE_IR SHALL copy ir_shift into ir in that cycle; ir is visible on the following cycle.
REQ-017 DR selection SHALL follow ir: IDCODE -> 32-bit id_shift, USER -> USER_WIDTH-bit user_shift, otherwise -> 1-bit bypass_reg.
REQ-018 CAPTURE_DR SHALL load the selected register: id_shift <= IDCODE_VAL, user_shift <= user_in, bypass_reg <= 0.
REQ-019 SHIFT_DR SHALL shift the selected register right, tdi into MSB; tdo = selected register bit 0 combinationally; unselected registers hold.
REQ-020 UPDATE_DR with USER selected SHALL copy user_shift into user_out; otherwise user_out holds.
REQ-021 PAUSE, EXIT1, EXIT2, SELECT, IDLE states SHALL hold all shift registers unchanged.
REQ-022 tdo SHALL be 0 whenever tdo_en is 0.
REQ-023 tap_state RESET SHALL force ir to IDCODE (1) on every clock while present; user_out holds.
REQ-024 ir SHALL change only on UPDATE_IR or RESET; a mid-shift change of instruction is impossible by construction.
REQ-025 Shifting longer than the register length SHALL continue to pass tdi through with latency equal to register length (BYPASS latency 1 cycle).

Reset
REQ-026 trst high at a rising edge SHALL set ir = IDCODE, ir_shift = 0, id_shift = 0, user_shift = 0, bypass_reg = 0, user_out = 0; tdo = 0 and tdo_en = 0 follow combinationally.
REQ-027 trst SHALL take priority over every tap_state action in the same cycle, including UPDATE_IR mid-operation.

Configuration
REQ-028 Macro TAP_USER_DR_EN defined: USER instruction, user_shift, user_in capture and user_out update SHALL be present.
REQ-029 Macro TAP_USER_DR_EN undefined: ir value 2 SHALL select BYPASS, user_out SHALL be constant 0, user_in SHALL be ignored.

Verification
REQ-030 trst 1 cycle, then CAPTURE_DR + 32x SHIFT_DR with tdi=0 -> tdo sequence equals IDCODE_VAL LSB first (1,0,0,0,...), tdo_en=1 throughout shift.
REQ-031 CAPTURE_IR, SHIFT_IR 4 cycles with tdi 1,1,1,1, EXIT1_IR, UPDATE_IR -> tdo during shift 1,0,0,0; ir = 4'hF next cycle; then CAPTURE_DR, SHIFT_DR tdi 1,0,1 -> tdo 0,1,0.
REQ-032 Load ir=2 (macro defined), user_in=8'hA5, CAPTURE_DR, 8x SHIFT_DR tdi bits of 8'h3C LSB first, UPDATE_DR -> tdo bits of 8'hA5 LSB first; user_out = 8'h3C; without macro user_out stays 0 and path is 1-bit bypass.
REQ-033 ir=4'hF, tap_state=RESET one cycle -> ir = 1; user_out unchanged.
REQ-034 SHIFT_DR 3 cycles, PAUSE_DR 5 cycles, EXIT2_DR, SHIFT_DR -> register contents unchanged across pause; shifting resumes from held bit.
REQ-035 trst asserted in the same cycle as UPDATE_IR with ir_shift=4'hF -> ir = 1, all shift registers 0.

Source files
------------

// File: rtl/tap_data_path.sv
// JTAG IR/DR datapath steered by an externally registered TAP state; USER DR present only with `TAP_USER_DR_EN.
// tdo is combinational from bit 0 of the active shift register; no backpressure, one bit moves per tclk.
module tap_data_path #(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int          USER_WIDTH = 8
) (
  input  logic                  tclk,
  input  logic                  trst,
  input  logic [4:0]            tap_state,
  input  logic                  tdi,
  input  logic [USER_WIDTH-1:0] user_in,
  output logic                  tdo,
  output logic                  tdo_en,
  output logic [IR_WIDTH-1:0]   ir,
  output logic [USER_WIDTH-1:0] user_out
);

  localparam logic [4:0] ST_RESET      = 5'd0;
  localparam logic [4:0] ST_CAPTURE_DR = 5'd3;
  localparam logic [4:0] ST_SHIFT_DR   = 5'd4;
  localparam logic [4:0] ST_UPDATE_DR  = 5'd8;
  localparam logic [4:0] ST_CAPTURE_IR = 5'd10;
  localparam logic [4:0] ST_SHIFT_IR   = 5'd11;
  localparam logic [4:0] ST_UPDATE_IR  = 5'd15;

  localparam logic [IR_WIDTH-1:0] INSTR_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] INSTR_USER   = IR_WIDTH'(2);

  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [31:0]         id_shift_q, id_shift_d;
  logic                bypass_q, bypass_d;
  logic                sel_id, sel_user;
  logic                shift_ir, shift_dr;
  logic                user_tdo;

  assign shift_ir = (tap_state == ST_SHIFT_IR);
  assign shift_dr = (tap_state == ST_SHIFT_DR);
  assign sel_id   = (ir_q == INSTR_IDCODE);

`ifdef TAP_USER_DR_EN
  logic [USER_WIDTH-1:0] user_shift_q, user_shift_d;
  logic [USER_WIDTH-1:0] user_out_q, user_out_d;

  assign sel_user = (ir_q == INSTR_USER);
  assign user_tdo = user_shift_q[0];
  assign user_out = user_out_q;

  always_comb begin
    user_shift_d = user_shift_q;
    user_out_d   = user_out_q;
    if (sel_user) begin
      case (tap_state)
        ST_CAPTURE_DR: user_shift_d = user_in;
        ST_SHIFT_DR:   user_shift_d = {tdi, user_shift_q[USER_WIDTH-1:1]};
        ST_UPDATE_DR:  user_out_d   = user_shift_q;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge tclk) begin
    if (trst) begin
      user_shift_q <= '0;
      user_out_q   <= '0;
    end else begin
      user_shift_q <= user_shift_d;
      user_out_q   <= user_out_d;
    end
  end
`else
  // Without the USER DR, instruction 2 falls through to BYPASS and user_in is dropped.
  logic unused_user_in;
  assign unused_user_in = ^user_in;
  assign sel_user       = 1'b0;
  assign user_tdo       = 1'b0;
  assign user_out       = '0;
`endif

  always_comb begin
    ir_d       = ir_q;
    ir_shift_d = ir_shift_q;
    id_shift_d = id_shift_q;
    bypass_d   = bypass_q;
    case (tap_state)
      ST_RESET:      ir_d       = INSTR_IDCODE;
      ST_CAPTURE_IR: ir_shift_d = IR_WIDTH'(1);
      ST_SHIFT_IR:   ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
      ST_UPDATE_IR:  ir_d       = ir_shift_q;
      ST_CAPTURE_DR: begin
        if (sel_id)         id_shift_d = IDCODE_VAL;
        else if (!sel_user) bypass_d   = 1'b0;
      end
      ST_SHIFT_DR: begin
        if (sel_id)         id_shift_d = {tdi, id_shift_q[31:1]};
        else if (!sel_user) bypass_d   = tdi;
      end
      default: ;
    endcase
  end

  always_ff @(posedge tclk) begin
    if (trst) begin
      ir_q       <= INSTR_IDCODE;
      ir_shift_q <= '0;
      id_shift_q <= '0;
      bypass_q   <= 1'b0;
    end else begin
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      id_shift_q <= id_shift_d;
      bypass_q   <= bypass_d;
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (shift_ir)      tdo = ir_shift_q[0];
    else if (shift_dr) tdo = sel_id ? id_shift_q[0] : (sel_user ? user_tdo : bypass_q);
  end

  assign tdo_en = shift_ir | shift_dr;
  assign ir     = ir_q;

endmodule

// File: tb/tb_tap_data_path.sv
// Bench for tap_data_path: directed scenarios plus random TAP traffic against a bit-queue model.
module tb_tap_data_path;
  localparam int          IRW = 4;
  localparam int          UW  = 8;
  localparam logic [31:0] ID  = 32'h1000_0001;

  logic           tclk, trst, tdi, tdo, tdo_en;
  logic [4:0]     tap_state;
  logic [UW-1:0]  user_in, user_out;
  logic [IRW-1:0] ir;

  int n_checks = 0;
  int n_fail   = 0;
  logic exp_tdo, exp_en;

  tap_data_path #(.IR_WIDTH(IRW), .IDCODE_VAL(ID), .USER_WIDTH(UW)) dut (
    .tclk(tclk), .trst(trst), .tap_state(tap_state), .tdi(tdi), .user_in(user_in),
    .tdo(tdo), .tdo_en(tdo_en), .ir(ir), .user_out(user_out)
  );

  initial tclk = 1'b0;
  always #5 tclk = ~tclk;

  // Model: each register is a queue of bits, front = bit 0 (next bit out of tdo).
  bit q_ir[$], q_id[$], q_user[$], q_byp[$];
  logic [IRW-1:0] m_ir;
  logic [UW-1:0]  m_uout;

  function automatic int q_len(input int w);
    case (w)
      0: return IRW;
      1: return 32;
      2: return UW;
      default: return 1;
    endcase
  endfunction

  function automatic void q_push(input int w, input bit b);
    case (w)
      0: q_ir.push_back(b);
      1: q_id.push_back(b);
      2: q_user.push_back(b);
      default: q_byp.push_back(b);
    endcase
  endfunction

  function automatic void q_drop(input int w);
    case (w)
      0: void'(q_ir.pop_front());
      1: void'(q_id.pop_front());
      2: void'(q_user.pop_front());
      default: void'(q_byp.pop_front());
    endcase
  endfunction

  function automatic bit q_at(input int w, input int i);
    case (w)
      0: return q_ir[i];
      1: return q_id[i];
      2: return q_user[i];
      default: return q_byp[i];
    endcase
  endfunction

  function automatic void q_load(input int w, input logic [31:0] v);
    for (int i = 0; i < q_len(w); i++) q_drop(w);
    for (int i = 0; i < q_len(w); i++) q_push(w, v[i]);
  endfunction

  function automatic void q_shift(input int w, input bit b);
    q_push(w, b);
    q_drop(w);
  endfunction

  function automatic logic [31:0] q_val(input int w);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < q_len(w); i++) v[i] = q_at(w, i);
    return v;
  endfunction

  function automatic int sel_dr();
    if (m_ir == IRW'(1)) return 1;
`ifdef TAP_USER_DR_EN
    if (m_ir == IRW'(2)) return 2;
`endif
    return 3;
  endfunction

  function automatic void model_step();
    logic [31:0] t;
    int s;
    s = sel_dr();
    if (trst) begin
      m_ir = IRW'(1);
      m_uout = '0;
      for (int w = 0; w < 4; w++) q_load(w, '0);
    end else begin
      case (tap_state)
        5'd0:  m_ir = IRW'(1);
        5'd10: q_load(0, 32'd1);
        5'd11: q_shift(0, tdi);
        5'd15: begin t = q_val(0); m_ir = t[IRW-1:0]; end
        5'd3:  q_load(s, (s == 1) ? ID : ((s == 2) ? 32'(user_in) : 32'd0));
        5'd4:  q_shift(s, tdi);
        5'd8:  if (s == 2) begin t = q_val(2); m_uout = t[UW-1:0]; end
        default: ;
      endcase
    end
  endfunction

  function automatic logic model_tdo();
    if (tap_state == 5'd11) return q_at(0, 0);
    if (tap_state == 5'd4)  return q_at(sel_dr(), 0);
    return 1'b0;
  endfunction

  // Advance the model over the posedge just taken, then present the next cycle's inputs.
  task automatic set_in(input logic [4:0] st, input logic d);
    @(negedge tclk);
    model_step();
    tap_state = st;
    tdi       = d;
    #1;
    exp_en  = (st == 5'd4) || (st == 5'd11);
    exp_tdo = model_tdo();
  endtask

  task automatic load_ir(input logic [IRW-1:0] v);
    set_in(5'd10, 1'b0);
    for (int i = 0; i < IRW; i++) set_in(5'd11, v[i]);
    set_in(5'd12, 1'b0);
    set_in(5'd15, 1'b0);
    set_in(5'd1, 1'b0);
  endtask

  task automatic test_reset();
    trst = 1'b1;
    set_in(5'd1, 1'b0);
    set_in(5'd1, 1'b0);
    n_checks++; if (ir !== IRW'(1)) begin n_fail++; $display("FAIL reset_ir: got %h expected 1", ir); end
    n_checks++; if (user_out !== '0) begin n_fail++; $display("FAIL reset_user_out: got %h expected 0", user_out); end
    n_checks++; if ({tdo, tdo_en} !== 2'b00) begin n_fail++; $display("FAIL reset_tdo: got %b%b expected 00", tdo, tdo_en); end
    trst = 1'b0;
  endtask

  task automatic test_idcode();
    logic [31:0] idv;
    idv = ID;
    trst = 1'b1;
    set_in(5'd1, 1'b0);
    trst = 1'b0;
    set_in(5'd3, 1'b0);
    for (int i = 0; i < 32; i++) begin
      set_in(5'd4, 1'b0);
      n_checks++; if (tdo !== idv[i]) begin n_fail++; $display("FAIL idcode_tdo bit %0d: got %b expected %b", i, tdo, idv[i]); end
      n_checks++; if (tdo_en !== 1'b1) begin n_fail++; $display("FAIL idcode_tdo_en bit %0d: got %b expected 1", i, tdo_en); end
    end
    set_in(5'd5, 1'b0);
    set_in(5'd8, 1'b0);
    set_in(5'd1, 1'b0);
  endtask

  task automatic test_bypass_ir();
    logic [3:0] ir_exp, dr_in, dr_exp;
    ir_exp = 4'b0001;
    dr_in  = 4'b0101;
    dr_exp = 4'b0010;
    set_in(5'd10, 1'b0);
    for (int i = 0; i < IRW; i++) begin
      set_in(5'd11, 1'b1);
      n_checks++; if (tdo !== ir_exp[i]) begin n_fail++; $display("FAIL ir_capture_tdo bit %0d: got %b expected %b", i, tdo, ir_exp[i]); end
    end
    set_in(5'd12, 1'b0);
    set_in(5'd15, 1'b0);
    set_in(5'd1, 1'b0);
    n_checks++; if (ir !== {IRW{1'b1}}) begin n_fail++; $display("FAIL ir_update: got %h expected %h", ir, {IRW{1'b1}}); end
    set_in(5'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_in(5'd4, dr_in[i]);
      n_checks++; if (tdo !== dr_exp[i]) begin n_fail++; $display("FAIL bypass_tdo bit %0d: got %b expected %b", i, tdo, dr_exp[i]); end
    end
    set_in(5'd5, 1'b0);
    set_in(5'd8, 1'b0);
    set_in(5'd1, 1'b0);
  endtask

  task automatic test_user();
    logic [7:0] pin, cap, exp_b;
    pin = 8'h3C;
    cap = 8'hA5;
    load_ir(IRW'(2));
    n_checks++; if (ir !== IRW'(2)) begin n_fail++; $display("FAIL user_ir: got %h expected 2", ir); end
    user_in = cap;
    set_in(5'd3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      set_in(5'd4, pin[i]);
`ifdef TAP_USER_DR_EN
      exp_b[i] = cap[i];
`else
      exp_b[i] = (i == 0) ? 1'b0 : pin[i-1];
`endif
      n_checks++; if (tdo !== exp_b[i]) begin n_fail++; $display("FAIL user_tdo bit %0d: got %b expected %b", i, tdo, exp_b[i]); end
    end
    user_in = 8'h00;
    set_in(5'd5, 1'b0);
    set_in(5'd8, 1'b0);
    set_in(5'd1, 1'b0);
`ifdef TAP_USER_DR_EN
    n_checks++; if (user_out !== 8'h3C) begin n_fail++; $display("FAIL user_out: got %h expected 3c", user_out); end
`else
    n_checks++; if (user_out !== 8'h00) begin n_fail++; $display("FAIL user_out: got %h expected 00", user_out); end
`endif
  endtask

  task automatic test_tap_reset();
    load_ir({IRW{1'b1}});
    n_checks++; if (ir !== {IRW{1'b1}}) begin n_fail++; $display("FAIL tapreset_pre_ir: got %h expected %h", ir, {IRW{1'b1}}); end
    set_in(5'd0, 1'b0);
    set_in(5'd1, 1'b0);
    n_checks++; if (ir !== IRW'(1)) begin n_fail++; $display("FAIL tapreset_ir: got %h expected 1", ir); end
    n_checks++; if (user_out !== m_uout) begin n_fail++; $display("FAIL tapreset_user_out: got %h expected %h", user_out, m_uout); end
  endtask

  task automatic test_pause();
    logic [34:0] seq;
    seq = {3'b111, ID};
    set_in(5'd3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      set_in(5'd4, 1'b1);
      n_checks++; if (tdo !== seq[k]) begin n_fail++; $display("FAIL pause_pre bit %0d: got %b expected %b", k, tdo, seq[k]); end
    end
    set_in(5'd5, 1'b0);
    for (int k = 0; k < 5; k++) begin
      set_in(5'd6, 1'b1);
      n_checks++; if ({tdo, tdo_en} !== 2'b00) begin n_fail++; $display("FAIL pause_hold cycle %0d: got %b%b expected 00", k, tdo, tdo_en); end
    end
    set_in(5'd7, 1'b1);
    for (int k = 3; k < 35; k++) begin
      set_in(5'd4, 1'b0);
      n_checks++; if (tdo !== seq[k]) begin n_fail++; $display("FAIL pause_resume bit %0d: got %b expected %b", k, tdo, seq[k]); end
    end
    set_in(5'd5, 1'b0);
    set_in(5'd8, 1'b0);
    set_in(5'd1, 1'b0);
  endtask

  task automatic test_trst_priority();
    set_in(5'd10, 1'b0);
    for (int i = 0; i < IRW; i++) set_in(5'd11, 1'b1);
    set_in(5'd12, 1'b0);
    set_in(5'd15, 1'b0);
    trst = 1'b1;
    set_in(5'd1, 1'b0);
    trst = 1'b0;
    n_checks++; if (ir !== IRW'(1)) begin n_fail++; $display("FAIL trst_prio_ir: got %h expected 1", ir); end
    n_checks++; if (user_out !== '0) begin n_fail++; $display("FAIL trst_prio_user_out: got %h expected 0", user_out); end
    for (int i = 0; i < IRW; i++) begin
      set_in(5'd11, 1'b0);
      n_checks++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL trst_prio_ir_shift bit %0d: got %b expected 0", i, tdo); end
    end
    for (int i = 0; i < 32; i++) begin
      set_in(5'd4, 1'b0);
      n_checks++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL trst_prio_id_shift bit %0d: got %b expected 0", i, tdo); end
    end
    set_in(5'd1, 1'b0);
  endtask

  task automatic test_random();
    logic [4:0] st;
    for (int c = 0; c < 1500; c++) begin
      st = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 15));
      set_in(st, 1'($urandom));
      n_checks++; if (tdo !== exp_tdo) begin n_fail++; $display("FAIL rand_tdo cycle %0d st %0d: got %b expected %b", c, st, tdo, exp_tdo); end
      n_checks++; if (tdo_en !== exp_en) begin n_fail++; $display("FAIL rand_tdo_en cycle %0d st %0d: got %b expected %b", c, st, tdo_en, exp_en); end
      n_checks++; if (ir !== m_ir) begin n_fail++; $display("FAIL rand_ir cycle %0d: got %h expected %h", c, ir, m_ir); end
      n_checks++; if (user_out !== m_uout) begin n_fail++; $display("FAIL rand_user_out cycle %0d: got %h expected %h", c, user_out, m_uout); end
      user_in = UW'($urandom);
      trst    = ($urandom_range(0, 63) == 0);
    end
    trst = 1'b0;
  endtask

  initial begin
    trst      = 1'b1;
    tap_state = 5'd1;
    tdi       = 1'b0;
    user_in   = '0;
    m_ir      = IRW'(1);
    m_uout    = '0;
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < q_len(w); i++) q_push(w, 1'b0);
    test_reset();
    test_idcode();
    test_bypass_ir();
    test_user();
    test_tap_reset();
    test_pause();
    test_trst_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
